// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 32x32 register file.
// Two requesters (ALU writeback and load return) share one write port through
// valid/ready handshakes. Loads have priority. A saturating wait counter bounds
// how many consecutive cycles a pending ALU writeback can lose to loads.
// The winning request is registered and drives the register file one cycle later.
module rf_write_arbiter #(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hold,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rdst,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rdst,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic        grant_src
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic [3:0]  alu_wait_q;
    logic [3:0]  alu_wait_d;
    logic        alu_grant;
    logic        mem_grant;

    logic        wr_en_q;
    logic [4:0]  wr_addr_q;
    logic [31:0] wr_data_q;
    logic        grant_src_q;

    // Grant decision: loads win unless the ALU has reached its wait bound.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (reset_n && !hold) begin
            if (alu_valid && mem_valid) begin
                if (alu_wait_q >= MaxWait) begin
                    alu_grant = 1'b1;
                end else begin
                    mem_grant = 1'b1;
                end
            end else begin
                alu_grant = alu_valid;
                mem_grant = mem_valid;
            end
        end
    end

    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;

    // Wait counter next state: counts losses to loads while the ALU is pending.
    // During hold there is no grant at all, so a pending ALU keeps its count.
    always_comb begin
        alu_wait_d = alu_wait_q;
        if (!alu_valid || alu_grant) begin
            alu_wait_d = '0;
        end else if (mem_grant && (alu_wait_q < MaxWait)) begin
            alu_wait_d = alu_wait_q + 4'd1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alu_wait_q <= '0;
        end else begin
            alu_wait_q <= alu_wait_d;
        end
    end

    // Write register: capture the winner; address/data/source hold when idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            grant_src_q <= 1'b0;
        end else begin
            wr_en_q <= alu_grant | mem_grant;
            if (mem_grant) begin
                wr_addr_q   <= mem_rdst;
                wr_data_q   <= mem_data;
                grant_src_q <= 1'b1;
            end else if (alu_grant) begin
                wr_addr_q   <= alu_rdst;
                wr_data_q   <= alu_data;
                grant_src_q <= 1'b0;
            end
        end
    end

    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign grant_src  = grant_src_q;

endmodule
